alarm_timer_digits: RTL

- Countdown timer and digit formatter for the alarm's arming and entry delays.
- Counts a loaded 3-digit BCD seconds value down to zero and raises an expiry pulse for the alarm FSM.
- Sits directly upstream of the 8-digit multiplexed 7-segment driver. Produces its eight 6-bit digit words {enable, hex[3:0], dp}.
- Digit 1 is the leftmost digit. dp=1 lights the decimal point.

---
 rtl/alarm_timer_digits.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_timer_digits.sv
// alarm_timer_digits: BCD seconds countdown for the alarm arming/entry delays,
// with an expiry pulse and an 8-digit word formatter for the 7-segment mux.
// Digit word layout: {enable, hex[3:0], dp}; digit 1 is the leftmost.
// Optional build macro TENTHS_EN: adds a tenths digit below units and shifts
// the displayed count one position left (0.1 s resolution).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | stopped, count 000
// S_RUN     | prescaler advancing, count decrements once per tick
// S_PAUSE   | prescaler and count frozen while pause is high
// S_EXPIRED | count reached zero, d6..d8 blink "000" until start/clear
module alarm_timer_digits #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [11:0] load_bcd,
  input  logic [3:0]  state_code,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic        running,
  output logic        expired,
  output logic        done
);

  // The prescaler doubles as the blink timer in EXPIRED, so it is sized for
  // the full second even when the tick period is shorter.
  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
`ifdef TENTHS_EN
  localparam int TICK_DIV = (CLK_HZ >= 10) ? (CLK_HZ / 10) : 1;
`else
  localparam int TICK_DIV = CLK_HZ;
`endif
  localparam logic [PW-1:0] TICK_TC  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] BLINK_TC = PW'(CLK_HZ / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t         state_q, state_d;
  logic [11:0]    count_q, count_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           blink_q, blink_d;
  logic           done_ev_q, done_ev_d;
  logic [11:0]    load_clamped;
  logic           at_zero;
`ifdef TENTHS_EN
  logic [3:0]     tenths_q, tenths_d;
`endif

  logic [5:0]     dig_d [1:8];
  logic [5:0]     dig_q [1:8];
  logic           running_q, expired_q, done_q;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // BCD decrement of {hundreds, tens, units}; never called on 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  assign load_clamped = {clamp9(load_bcd[11:8]), clamp9(load_bcd[7:4]), clamp9(load_bcd[3:0])};

  // Next-state, count, prescaler and blink; clear beats start beats tick/pause.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    blink_d   = blink_q;
    done_ev_d = 1'b0;
    at_zero   = 1'b0;
`ifdef TENTHS_EN
    tenths_d  = tenths_q;
`endif
    if (clear) begin
      state_d = S_IDLE;
      count_d = 12'h000;
      presc_d = '0;
      blink_d = 1'b0;
`ifdef TENTHS_EN
      tenths_d = 4'd0;
`endif
    end else if (start) begin
      count_d = load_clamped;
      presc_d = '0;
      blink_d = 1'b0;
`ifdef TENTHS_EN
      tenths_d = 4'd0;
`endif
      if (load_clamped == 12'h000) begin
        state_d   = S_EXPIRED;
        done_ev_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN, S_PAUSE: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            // Leaving PAUSE advances the prescaler in the same cycle so the
            // frozen interval equals exactly the cycles pause was high.
            state_d = S_RUN;
            if (presc_q == TICK_TC) begin
              presc_d = '0;
`ifdef TENTHS_EN
              if (tenths_q != 4'd0) begin
                tenths_d = tenths_q - 4'd1;
              end else begin
                tenths_d = 4'd9;
                count_d  = bcd_dec(count_q);
              end
              at_zero = (count_d == 12'h000) && (tenths_d == 4'd0);
`else
              count_d = bcd_dec(count_q);
              at_zero = (count_d == 12'h000);
`endif
              if (at_zero) begin
                state_d   = S_EXPIRED;
                done_ev_d = 1'b1;
                blink_d   = 1'b0;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        S_EXPIRED: begin
          if (presc_q == BLINK_TC) begin
            presc_d = '0;
            blink_d = ~blink_q;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit words from the current state/count; registered below.
  always_comb begin
    for (int i = 1; i <= 8; i++) dig_d[i] = 6'b000000;
    dig_d[1] = {1'b1, state_code, (state_q == S_RUN) || (state_q == S_PAUSE)};
`ifdef TENTHS_EN
    if (state_q == S_EXPIRED) begin
      dig_d[5] = {~blink_q, 4'd0, 1'b0};
      dig_d[6] = {~blink_q, 4'd0, 1'b0};
      dig_d[7] = {~blink_q, 4'd0, ~blink_q};
      dig_d[8] = {~blink_q, 4'd0, 1'b0};
    end else begin
      if (count_q[11:8] != 4'd0)
        dig_d[5] = {1'b1, count_q[11:8], 1'b0};
      if (count_q[11:4] != 8'd0)
        dig_d[6] = {1'b1, count_q[7:4], 1'b0};
      dig_d[7] = {1'b1, count_q[3:0], 1'b1};
      dig_d[8] = {1'b1, tenths_q, 1'b0};
    end
`else
    if (state_q == S_EXPIRED) begin
      dig_d[6] = {~blink_q, 4'd0, 1'b0};
      dig_d[7] = {~blink_q, 4'd0, 1'b0};
      dig_d[8] = {~blink_q, 4'd0, 1'b0};
    end else begin
      if (count_q[11:8] != 4'd0)
        dig_d[6] = {1'b1, count_q[11:8], 1'b0};
      if (count_q[11:4] != 8'd0)
        dig_d[7] = {1'b1, count_q[7:4], 1'b0};
      dig_d[8] = {1'b1, count_q[3:0], 1'b0};
    end
`endif
  end

  // Core state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 12'h000;
      presc_q   <= '0;
      blink_q   <= 1'b0;
      done_ev_q <= 1'b0;
`ifdef TENTHS_EN
      tenths_q  <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      done_ev_q <= done_ev_d;
`ifdef TENTHS_EN
      tenths_q  <= tenths_d;
`endif
    end
  end

  // Output registers: one cycle behind the state, status flags kept aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i <= 7; i++) dig_q[i] <= 6'b000000;
      dig_q[8]  <= 6'b100000;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      for (int i = 1; i <= 8; i++) dig_q[i] <= dig_d[i];
      running_q <= (state_q == S_RUN) || (state_q == S_PAUSE);
      expired_q <= (state_q == S_EXPIRED);
      done_q    <= done_ev_q;
    end
  end

  assign d1      = dig_q[1];
  assign d2      = dig_q[2];
  assign d3      = dig_q[3];
  assign d4      = dig_q[4];
  assign d5      = dig_q[5];
  assign d6      = dig_q[6];
  assign d7      = dig_q[7];
  assign d8      = dig_q[8];
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;

endmodule
